// File: rtl/fifo_csr.sv
// fifo_csr: per-channel FIFO control/status register block with sticky events and interrupt
module fifo_csr #(
    parameter int NCH    = 2,
    parameter int DATA_W = 16,
    parameter int MRGN_W = 4,
    parameter int ADDR_W = $clog2(4 * NCH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic                  o_ack,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_err,
    input  logic [NCH-1:0]        i_full,
    input  logic [NCH-1:0]        i_near_full,
    input  logic [NCH-1:0]        i_overflow,
    input  logic [NCH-1:0]        i_empty,
    input  logic [NCH-1:0]        i_near_empty,
    input  logic [NCH-1:0]        i_underflow,
    output logic [NCH-1:0]        o_wptr_clr,
    output logic [NCH-1:0]        o_rptr_clr,
    output logic [NCH*MRGN_W-1:0] o_near_full_mrgn,
    output logic [NCH*MRGN_W-1:0] o_near_empty_mrgn,
    output logic                  o_irq
);
    // margin reset value is 4, saturated when the field cannot hold 4
    localparam int MRST = (MRGN_W >= 3) ? 4 : (1 << MRGN_W) - 1;
    localparam logic [ADDR_W-1:0] IRQ_ADDR = ADDR_W'(4 * NCH);
    logic [NCH-1:0][MRGN_W-1:0] nf_mrgn, ne_mrgn;
    logic [NCH-1:0][3:0] evt, irq_en, evt_set, evt_clr;
    logic [NCH-1:0] prev_full, prev_empty, wr_ctrl, wr_mrgn, wr_evt;
    logic [DATA_W-1:0] rd_val;
    logic hit, wr_irq;
    logic unused_wdata;
    assign unused_wdata = ^i_wdata;
    assign o_near_full_mrgn  = nf_mrgn;
    assign o_near_empty_mrgn = ne_mrgn;
    assign wr_irq = i_req & i_we & (i_addr == IRQ_ADDR);
    // address decode, read mux and per-channel event set/clear terms
    always_comb begin
        rd_val  = '0;
        hit     = (i_addr == IRQ_ADDR);
        wr_ctrl = '0;
        wr_mrgn = '0;
        wr_evt  = '0;
        evt_set = '0;
        evt_clr = '0;
        if (hit) rd_val = DATA_W'(irq_en);
        for (int c = 0; c < NCH; c++) begin
            if (i_addr[ADDR_W-1:2] == (ADDR_W-2)'(c)) begin
                hit        = 1'b1;
                rd_val     = (i_addr[1:0] == 2'd1) ? ((DATA_W'(ne_mrgn[c]) << 8) | DATA_W'(nf_mrgn[c])) :
                             (i_addr[1:0] == 2'd2) ? DATA_W'({i_near_empty[c], i_empty[c], i_near_full[c], i_full[c]}) :
                             (i_addr[1:0] == 2'd3) ? DATA_W'(evt[c]) : '0;
                wr_ctrl[c] = i_req & i_we & (i_addr[1:0] == 2'd0);
                wr_mrgn[c] = i_req & i_we & (i_addr[1:0] == 2'd1);
                wr_evt[c]  = i_req & i_we & (i_addr[1:0] == 2'd3);
            end
            evt_set[c] = {i_empty[c] & ~prev_empty[c], i_full[c] & ~prev_full[c], i_underflow[c], i_overflow[c]};
            evt_clr[c] = wr_evt[c] ? i_wdata[3:0] : 4'd0;
        end
    end
    // bus response, clear pulses, register updates and interrupt
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ack      <= 1'b0;
            o_err      <= 1'b0;
            o_rdata    <= '0;
            o_irq      <= 1'b0;
            o_wptr_clr <= '0;
            o_rptr_clr <= '0;
            evt        <= '0;
            irq_en     <= '0;
            prev_full  <= '0;
            prev_empty <= '1;
            for (int c = 0; c < NCH; c++) begin
                nf_mrgn[c] <= MRGN_W'(MRST);
                ne_mrgn[c] <= MRGN_W'(MRST);
            end
        end else begin
            o_ack      <= i_req;
            o_err      <= i_req & ~hit;
            o_rdata    <= (i_req & ~i_we) ? rd_val : '0;
            o_irq      <= |(evt & irq_en);
            o_wptr_clr <= wr_ctrl & {NCH{i_wdata[0]}};
            o_rptr_clr <= wr_ctrl & {NCH{i_wdata[1]}};
            evt        <= (evt & ~evt_clr) | evt_set;
            prev_full  <= i_full;
            prev_empty <= i_empty;
            if (wr_irq) irq_en <= (4 * NCH)'(i_wdata);
            for (int c = 0; c < NCH; c++) begin
                if (wr_mrgn[c]) begin
                    nf_mrgn[c] <= i_wdata[MRGN_W-1:0];
                    ne_mrgn[c] <= i_wdata[8+:MRGN_W];
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_csr.sv
// tb_fifo_csr: scoreboard bench for fifo_csr with a register-map reference model
`timescale 1ns/1ps
module tb_fifo_csr;
    localparam int NCH = 2;
    localparam int DW  = 16;
    localparam int MW  = 4;
    localparam int AW  = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req = 1'b0, we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic ack, err, irq;
    logic [DW-1:0] rdata;
    logic [NCH-1:0] full = '0, near_full = '0, overflow = '0, empty = '1, near_empty = '0, underflow = '0;
    logic [NCH-1:0] wclr, rclr;
    logic [NCH*MW-1:0] nf_out, ne_out;
    logic [NCH-1:0] st_fu = '0, st_nfu = '0, st_ov = '0, st_em = '1, st_nem = '0, st_un = '0;
    int vectors = 0, miscompares = 0;
    typedef struct {
        logic ack, err, irq;
        logic [DW-1:0] rdata;
        logic [NCH-1:0] wclr, rclr;
        logic [NCH*MW-1:0] nf, ne;
    } exp_t;
    exp_t q[$];
    int m_nf[NCH], m_ne[NCH], m_evt[NCH], m_en;
    bit m_pf[NCH], m_pe[NCH];

    always #5 clk = ~clk;

    fifo_csr #(.NCH(NCH), .DATA_W(DW), .MRGN_W(MW), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_ack(ack), .o_rdata(rdata), .o_err(err),
        .i_full(full), .i_near_full(near_full), .i_overflow(overflow),
        .i_empty(empty), .i_near_empty(near_empty), .i_underflow(underflow),
        .o_wptr_clr(wclr), .o_rptr_clr(rclr),
        .o_near_full_mrgn(nf_out), .o_near_empty_mrgn(ne_out), .o_irq(irq));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_nf[k] = 4; m_ne[k] = 4; m_evt[k] = 0; m_pf[k] = 0; m_pe[k] = 1;
        end
        m_en = 0;
    endtask

    // one bus cycle: drive, predict the next-cycle outputs, advance the model
    task automatic cyc(input bit rq, input bit w, input int a, input int d);
        exp_t e;
        int val, c, r, clr, set;
        bit hit;
        @(negedge clk);
        req = rq; we = w; addr = a[AW-1:0]; wdata = d[DW-1:0];
        full = st_fu; near_full = st_nfu; overflow = st_ov;
        empty = st_em; near_empty = st_nem; underflow = st_un;
        c = a / 4; r = a % 4;
        hit = (a == 4 * NCH) || (c < NCH);
        val = 0;
        if (a == 4 * NCH) val = m_en;
        else if (c < NCH)
            val = (r == 1) ? (m_ne[c] * 256 + m_nf[c]) :
                  (r == 2) ? 8 * st_nem[c] + 4 * st_em[c] + 2 * st_nfu[c] + st_fu[c] :
                  (r == 3) ? m_evt[c] : 0;
        e.ack = rq;
        e.err = rq && !hit;
        e.rdata = (rq && !w && hit) ? val[DW-1:0] : '0;
        e.irq = 1'b0;
        for (int k = 0; k < NCH; k++)
            if ((m_evt[k] & (m_en >> (4 * k)) & 15) != 0) e.irq = 1'b1;
        e.wclr = '0; e.rclr = '0;
        for (int k = 0; k < NCH; k++) begin
            clr = 0;
            if (rq && w && c == k) begin
                if (r == 0) begin e.wclr[k] = d[0]; e.rclr[k] = d[1]; end
                if (r == 1) begin m_nf[k] = d % 16; m_ne[k] = (d / 256) % 16; end
                if (r == 3) clr = d % 16;
            end
            set = st_ov[k] + 2 * st_un[k] + 4 * (st_fu[k] && !m_pf[k]) + 8 * (st_em[k] && !m_pe[k]);
            m_evt[k] = (m_evt[k] & ~clr) | set;
            m_pf[k] = st_fu[k]; m_pe[k] = st_em[k];
            e.nf[k*MW+:MW] = m_nf[k][MW-1:0];
            e.ne[k*MW+:MW] = m_ne[k][MW-1:0];
        end
        if (rq && w && a == 4 * NCH) m_en = d % 256;
        q.push_back(e);
    endtask

    // monitor: compare every DUT cycle against the oldest prediction
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ack", ack, e.ack);
            chk("err", err, e.err);
            chk("rdata", rdata, e.rdata);
            chk("irq", irq, e.irq);
            chk("wptr_clr", wclr, e.wclr);
            chk("rptr_clr", rclr, e.rclr);
            chk("nf_mrgn", nf_out, e.nf);
            chk("ne_mrgn", ne_out, e.ne);
        end
    end

    task automatic quiet();
        st_fu = '0; st_nfu = '0; st_ov = '0; st_em = '1; st_nem = '0; st_un = '0;
        full = '0; near_full = '0; overflow = '0; empty = '1; near_empty = '0; underflow = '0;
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            st_fu = NCH'($urandom); st_nfu = NCH'($urandom);
            st_em = NCH'($urandom); st_nem = NCH'($urandom);
            for (int k = 0; k < NCH; k++) begin
                st_ov[k] = ($urandom_range(0, 7) == 0);
                st_un[k] = ($urandom_range(0, 7) == 0);
            end
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom & 16'hFFFF);
        end
        quiet();
    endtask

    initial begin
        quiet();
        model_reset();
        #12;
        chk("rst_ack", ack, 0);
        chk("rst_irq", irq, 0);
        chk("rst_nf", nf_out, 8'h44);
        chk("rst_ne", ne_out, 8'h44);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 5, 0);
        cyc(0, 0, 0, 0);
        chk("ch1_ne_mrgn", ne_out[7:4], 4);
        cyc(1, 1, 0, 3);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        st_ov = 2'b10;
        cyc(1, 1, 8, 16'h0010);
        st_ov = '0;
        cyc(0, 0, 0, 0);
        cyc(1, 0, 7, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 1, 7, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 7, 0);
        st_un = 2'b01;
        cyc(1, 1, 3, 2);
        cyc(1, 0, 3, 0);
        st_un = '0;
        cyc(1, 1, 3, 2);
        cyc(1, 0, 3, 0);
        cyc(1, 0, 9, 0);
        cyc(1, 1, 9, 16'hFFFF);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 8, 0);
        rand_cycles(400);
        cyc(1, 1, 1, 16'h0202);
        cyc(1, 1, 0, 3);
        @(negedge clk);
        req = 1; we = 1; addr = 1; wdata = 16'h0707;
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_ack", ack, 0);
        chk("rstmid_wclr", wclr, 0);
        chk("rstmid_rclr", rclr, 0);
        chk("rstmid_nf", nf_out, 8'h44);
        chk("rstmid_ne", ne_out, 8'h44);
        @(negedge clk);
        req = 0; we = 0;
        quiet();
        model_reset();
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 1, 0);
        rand_cycles(150);
        cyc(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
